// File: rtl/uart_tx.sv
// UART transmitter with a small transmit FIFO.
// Frames are start bit (low), DATA_LENGTH data bits LSB first, then STOP_BITS stop bits (high).
// Each bit lasts CLKS_PER_BIT clock cycles. Words queued in the FIFO go out back-to-back
// with no idle gap between frames.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_LENGTH  = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [DATA_LENGTH-1:0] data_i,
    input  logic                   data_v_i,
    output logic                   ready_o,
    output logic                   tx_o,
    output logic                   busy_o
);

    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    // One extra pointer bit separates "full" from "empty" when the addresses match.
    localparam int unsigned PtrW  = AddrW + 1;
    localparam int unsigned CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW  = $clog2(DATA_LENGTH + 1);

    localparam logic [CntW-1:0] ClkLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] DataLast = BitW'(DATA_LENGTH - 1);
    localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [DATA_LENGTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_LENGTH-1:0] mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic                   ready_q, ready_d;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic [DATA_LENGTH-1:0] fifo_head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_head  = mem_q[rd_ptr_q[AddrW-1:0]];
    // ready_q is a flop, so acceptance never depends combinationally on data_v_i.
    assign push       = data_v_i & ready_q;

    // FIFO storage and pointer next-state; ready tracks "not full" of the next pointers.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AddrW-1:0]] = data_i;
            wr_ptr_d                   = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        ready_d = !((wr_ptr_d[PtrW-1] != rd_ptr_d[PtrW-1]) &&
                    (wr_ptr_d[AddrW-1:0] == rd_ptr_d[AddrW-1:0]));
    end

    // FIFO state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic [CntW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_LENGTH-1:0] shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   clk_last;

    assign clk_last = (clk_cnt_q == ClkLast);

    // Next-state logic: bit timing, bit counting and FIFO pops.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pop       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_head;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = StStart;
                end
            end

            StStart: begin
                if (clk_last) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = StData;
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end

            StData: begin
                if (clk_last) begin
                    clk_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    if (bit_cnt_q == DataLast) begin
                        bit_cnt_d = '0;
                        state_d   = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end

            StStop: begin
                if (clk_last) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == StopLast) begin
                        bit_cnt_d = '0;
                        // Chain straight into the next frame when more data is queued.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_head;
                            state_d = StStart;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Line level and busy are registered from the current state, so both trail the FSM by one
    // cycle and stay aligned with each other: busy drops exactly when the stop bit ends on tx_o.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            StIdle:  tx_d = 1'b1;
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_q[0];
            StStop:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_q != StIdle) || !fifo_empty;
    end

    // FSM, counters, shift register and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign ready_o = ready_q;
    assign tx_o    = tx_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of single frames with hand-computed line patterns,
// plus directed sequences for back-to-back frames, FIFO full, reset mid-frame and two stop bits.
module tb_uart_tx;

    localparam int unsigned C  = 16;
    localparam int unsigned C2 = 4;
    localparam int unsigned FL = 10 * C;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       data_v;
    logic       ready;
    logic       tx;
    logic       busy;
    logic [7:0] data2;
    logic       data_v2;
    logic       ready2;
    logic       tx2;
    logic       busy2;

    always #5 clk = ~clk;

    uart_tx #(
        .CLKS_PER_BIT(C),
        .DATA_LENGTH (8),
        .STOP_BITS   (1),
        .FIFO_DEPTH  (4)
    ) u_dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .data_i  (data),
        .data_v_i(data_v),
        .ready_o (ready),
        .tx_o    (tx),
        .busy_o  (busy)
    );

    uart_tx #(
        .CLKS_PER_BIT(C2),
        .DATA_LENGTH (8),
        .STOP_BITS   (2),
        .FIFO_DEPTH  (4)
    ) u_dut2 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .data_i  (data2),
        .data_v_i(data_v2),
        .ready_o (ready2),
        .tx_o    (tx2),
        .busy_o  (busy2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // line levels in transmission order, bit 9 first
    } vec_t;

    vec_t       vecs [6];
    logic       rdy_hist [256];
    logic [7:0] words [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1ns past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] d);
        logic [9:0] f;
        f[9] = 1'b0;
        for (int k = 0; k < 8; k++) f[8-k] = d[k];
        f[0] = 1'b1;
        return f;
    endfunction

    // Called 1ns after the first edge of a frame; returns 1ns after the frame's last edge minus one.
    task automatic check_frame(input logic [9:0] pat, input string name);
        step(C / 2);
        for (int b = 0; b < 10; b++) begin
            chk($sformatf("%s bit%0d", name, b), tx, pat[9-b]);
            if (b < 9) step(C);
        end
        step(C / 2 - 1);
    endtask

    task automatic push(input logic [7:0] d);
        data   = d;
        data_v = 1'b1;
        step(1);
        data_v = 1'b0;
        data   = ~d;  // later changes must not affect the queued word
    endtask

    // Four words on consecutive edges, decoded as four contiguous frames.
    task automatic run_burst(input string name);
        fork
            begin
                data_v = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    data = words[i];
                    chk($sformatf("%s ready push%0d", name, i), ready, 1);
                    step(1);
                end
                data_v = 1'b0;
                data   = 8'h00;
            end
            begin
                step(3);
                for (int j = 0; j < 4; j++) begin
                    check_frame(frame_of(words[j]), $sformatf("%s f%0d", name, j));
                    step(1);
                end
                chk({name, " busy end"}, busy, 0);
                chk({name, " tx end"}, tx, 1);
            end
        join
    endtask

    initial begin
        logic       bad;
        int         cnt;
        logic       r;
        logic       expb;

        vecs[0] = '{8'h55, 10'b0_10101010_1};
        vecs[1] = '{8'hA5, 10'b0_10100101_1};
        vecs[2] = '{8'h3C, 10'b0_00111100_1};
        vecs[3] = '{8'hC2, 10'b0_01000011_1};
        vecs[4] = '{8'h01, 10'b0_10000000_1};
        vecs[5] = '{8'hFF, 10'b0_11111111_1};

        // Reset behaviour
        rst_n   = 1'b0;
        data    = 8'h00;
        data_v  = 1'b0;
        data2   = 8'h00;
        data_v2 = 1'b0;
        step(3);
        chk("rst tx", tx, 1);
        chk("rst ready", ready, 0);
        chk("rst busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready before first edge", ready, 0);
        step(1);
        chk("ready after first edge", ready, 1);
        chk("idle tx", tx, 1);
        step(2);

        // Single frames from the table
        for (int v = 0; v < 6; v++) begin
            chk($sformatf("v%0d busy pre", v), busy, 0);
            push(vecs[v].data);
            chk($sformatf("v%0d tx at N", v), tx, 1);
            step(1);
            chk($sformatf("v%0d tx at N+1", v), tx, 1);
            chk($sformatf("v%0d busy at N+1", v), busy, 1);
            step(1);
            chk($sformatf("v%0d tx fall N+2", v), tx, 0);
            check_frame(vecs[v].frame, $sformatf("v%0d", v));
            chk($sformatf("v%0d busy last stop", v), busy, 1);
            step(1);
            chk($sformatf("v%0d busy after frame", v), busy, 0);
            chk($sformatf("v%0d tx after frame", v), tx, 1);
            step(2);
        end

        // Back-to-back burst
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00;
        run_burst("b2b");
        step(2);

        // Random burst
        for (int i = 0; i < 4; i++) words[i] = 8'($urandom_range(0, 255));
        run_burst("rnd");
        step(2);

        // FIFO full with data_v held high
        for (int i = 0; i < 256; i++) rdy_hist[i] = 1'b0;
        fork
            begin
                data   = 8'h10;
                data_v = 1'b1;
                cnt    = 0;
                for (int i = 0; i < 2000; i++) begin
                    r = ready;
                    if (i < 256) rdy_hist[i] = r;
                    step(1);
                    if (r) begin
                        cnt++;
                        data = data + 8'd1;
                        if (cnt == 8) begin
                            data_v = 1'b0;
                            break;
                        end
                    end
                end
            end
            begin
                step(3);
                for (int j = 0; j < 8; j++) begin
                    check_frame(frame_of(8'(8'h10 + j)), $sformatf("full f%0d", j));
                    step(1);
                end
                chk("full busy end", busy, 0);
            end
        join
        chk("full accepted", cnt, 8);
        for (int i = 0; i < 5; i++) chk($sformatf("full ready fill%0d", i), rdy_hist[i], 1);
        chk("full ready low", rdy_hist[5], 0);
        bad = 1'b0;
        for (int i = 6; i <= FL + 1; i++) if (rdy_hist[i] !== 1'b0) bad = 1'b1;
        chk("full ready stays low", bad, 0);
        chk("full ready after pop", rdy_hist[FL + 2], 1);
        chk("full ready refilled", rdy_hist[FL + 3], 0);
        step(2);

        // Reset in the middle of bit 4 of 0x81 with two words queued
        data_v = 1'b1;
        data = 8'h81; step(1);
        data = 8'h11; step(1);
        data = 8'h22; step(1);
        data_v = 1'b0;
        step(5 * C + C / 2);
        chk("mid-frame tx bit4", tx, 0);
        chk("mid-frame busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("reset tx forced", tx, 1);
        chk("reset busy", busy, 0);
        chk("reset ready", ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        chk("post-reset ready", ready, 1);
        bad = 1'b0;
        for (int i = 0; i < 3 * FL; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
            step(1);
        end
        chk("post-reset quiet", bad, 0);
        push(8'h3C);
        step(1);
        check_frame(frame_of(8'h3C), "post-reset frame");
        step(3);

        // Two stop bits on the second instance: 0x00 then 0xFF
        data2   = 8'h00;
        data_v2 = 1'b1;
        step(1);
        data2 = 8'hFF;
        step(1);
        data_v2 = 1'b0;
        chk("sb2 tx at N+1", tx2, 1);
        step(1);
        for (int i = 0; i < 46; i++) begin
            expb = (i < 36) ? 1'b0 : ((i < 44) ? 1'b1 : 1'b0);
            chk($sformatf("sb2 cyc%0d", i), tx2, expb);
            step(1);
        end
        step(50);
        chk("sb2 idle tx", tx2, 1);
        chk("sb2 idle busy", busy2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk_i cycles per transmitted bit (legal 2..255).
REQ-002 Parameter DATA_LENGTH, default 8, data bits per frame.
REQ-003 Parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-004 Parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, legal 2..16).
REQ-005 clk_i  input  1  single clock; all logic on its rising edge.
REQ-006 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-007 data_i  input  DATA_LENGTH  word to transmit.
REQ-008 data_v_i  input  1  data_i valid.
REQ-009 ready_o  output  1  block can accept a word this cycle.
REQ-010 tx_o  output  1  serial line, idle high.
REQ-011 busy_o  output  1  frame in progress or FIFO non-empty.

Function
REQ-012 A word SHALL be accepted on a rising edge where data_v_i and ready_o are both high; data_i SHALL be ignored at all other edges.
REQ-013 ready_o SHALL equal "FIFO not full", driven from registered state only, with no combinational path from data_v_i.
REQ-014 When the FIFO is full, ready_o SHALL be low even if a word is popped that cycle; push-while-full SHALL be impossible.
REQ-015 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the occupancy unchanged and preserve order.
REQ-016 Push into an empty FIFO while IDLE SHALL be supported; the word SHALL be popped on the following edge.
REQ-017 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-018 IDLE: tx_o=1; on an edge with FIFO non-empty, pop the head word into the shift register and go to START.
REQ-019 START: tx_o=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-020 DATA: DATA_LENGTH bits, LSB first, each held exactly CLKS_PER_BIT cycles; then go to STOP.
REQ-021 STOP: tx_o=1 for STOP_BITS*CLKS_PER_BIT cycles; on its last cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
REQ-022 tx_o SHALL be a registered output, glitch-free.
REQ-023 Latency: a word accepted at edge N into an empty FIFO with the FSM in IDLE SHALL give a tx_o falling edge at edge N+2.
REQ-024 Frame length SHALL be exactly (1+DATA_LENGTH+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-025 The bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap.
REQ-026 The bit counter SHALL be clog2(DATA_LENGTH+1) bits wide; neither counter SHALL overflow.
REQ-027 The FIFO read and write pointers SHALL be one bit wider than clog2(FIFO_DEPTH) for full/empty detection and SHALL wrap modulo 2*FIFO_DEPTH.
REQ-028 busy_o SHALL be high when state != IDLE or the FIFO is non-empty.
REQ-029 Changes to data_i after acceptance SHALL NOT affect a frame already queued or in flight.

Reset
REQ-030 While rst_n_i=0: tx_o=1, ready_o=0, busy_o=0, state=IDLE, counters=0, FIFO empty.
REQ-031 ready_o SHALL rise on the first edge after rst_n_i deasserts.
REQ-032 Reset asserted mid-frame SHALL immediately force tx_o=1 and discard the in-flight frame and all queued words; no partial frame SHALL resume after release.

Verification
REQ-033 CLKS_PER_BIT=16, send 0x55 -> tx_o low at N+2, then bits 1,0,1,0,1,0,1,0 of 16 cycles each, stop high; frame is 160 cycles; busy_o falls after the stop bit.
REQ-034 Push 0xA5, 0x3C, 0xFF, 0x00 back-to-back -> ready_o stays high and all are accepted; four contiguous frames with no idle cycles; decoded 0xA5, 0x3C, 0xFF, 0x00 in order.
REQ-035 FIFO_DEPTH=4, hold data_v_i high with incrementing data from 0x10 -> ready_o falls once the FIFO is full; ready_o returns high one cycle after each pop; no word is lost or duplicated.
REQ-036 Loopback to the existing UART receiver at matching rate, random 256 words -> every word is received correctly with the receiver's valid flag pulsed once per word.
REQ-037 Assert rst_n_i low at the 5th data bit of 0x81 with 2 words queued -> tx_o=1 within the same cycle; after release, tx_o stays high and busy_o=0 until new data is pushed.
REQ-038 STOP_BITS=2, send 0x00 -> tx_o is low for 9*CLKS_PER_BIT cycles, then high for 2*CLKS_PER_BIT cycles before the next start bit.
